// File: rtl/banked_mem_pkg.sv
// Shared constants and types for the four-bank interleaved word memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package banked_mem_pkg;

  localparam int NUM_BANKS       = 4;
  localparam int BANK_CYCLES_DEF = 4;
  localparam int RD_LAT_DEF      = 2;

  // Bank select lives just above the byte-within-word bit.
  localparam int BANK_SEL_MSB = 2;
  localparam int BANK_SEL_LSB = 1;

  typedef logic [1:0] bank_sel_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

endpackage

// File: rtl/banked_mem_responder_mem_bank.sv
// One memory bank: word array, occupancy counter and two-stage read pipeline.
// Latency: write lands at end of accept cycle; read data valid 2 cycles after accept.
// Backpressure: none inside; busy tells the top level to stall requests to this bank.
module mem_bank
  import banked_mem_pkg::*;
#(
  parameter int BANK_CYCLES = BANK_CYCLES_DEF,
  parameter int ROW_BITS    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acc,
  input  logic                wr,
  input  logic [ROW_BITS-1:0] row,
  input  logic [15:0]         wdata,
  output logic                busy,
  output logic                rd_vld,
  output logic [15:0]         rd_dat
);

  localparam int CNT_W = $clog2(BANK_CYCLES);

  logic [CNT_W-1:0]    cnt;
  logic [15:0]         mem [2**ROW_BITS];
  logic                s1_vld;
  logic [ROW_BITS-1:0] s1_row;

  // Occupancy counter: reload on accept, otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (acc) begin
      cnt <= CNT_W'(BANK_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (acc && wr) begin
      mem[row] <= wdata;
    end
  end

  // Read stage 1: capture the accepted read's row.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_row <= '0;
    end else begin
      s1_vld <= acc && !wr;
      s1_row <= row;
    end
  end

  // Read stage 2: register the array word, zeroed when no read is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= 1'b0;
      rd_dat <= '0;
    end else begin
      rd_vld <= s1_vld;
      rd_dat <= s1_vld ? mem[s1_row] : '0;
    end
  end

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved 16-bit memory responder; bank = addr[2:1]. Optional macro MEM_ALIGN_CHECK_EN rejects odd addresses.
// Latency: one request per cycle; read data_valid exactly 2 cycles after acceptance, in order.
// Backpressure: stall=1 while the addressed bank is busy; requester holds the request, nothing is queued.
module banked_mem_responder
  import banked_mem_pkg::*;
#(
  parameter int BANK_CYCLES = BANK_CYCLES_DEF,
  parameter int RD_LAT      = RD_LAT_DEF,
  parameter int ROW_BITS    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic [15:0]          data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [15:0]          data_out,
  output logic                 data_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  // The read pipeline is hard-wired at two register stages.
  if (RD_LAT != 2) begin : g_rd_lat_chk
    $error("banked_mem_responder: RD_LAT must be 2");
  end
  if (BANK_CYCLES < 2 || BANK_CYCLES > 8) begin : g_bank_cycles_chk
    $error("banked_mem_responder: BANK_CYCLES must be in 2..8");
  end

  req_t                req;
  bank_sel_t           bsel;
  logic [ROW_BITS-1:0] row;
  logic                req_any;
  logic                err_raw;
  logic                acc;
  logic                rd_vld [NUM_BANKS];
  logic [15:0]         rd_dat [NUM_BANKS];
  logic                unused_addr_bits;

  assign req     = '{rd: rd, wr: wr, addr: addr, data: data_in};
  assign bsel    = req.addr[BANK_SEL_MSB:BANK_SEL_LSB];
  assign row     = req.addr[ROW_BITS+2:3];
  assign req_any = req.rd | req.wr;

  // High address bits alias; the byte bit only matters with the alignment check.
  assign unused_addr_bits = ^{req.addr[15:ROW_BITS+3], req.addr[0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign err_raw = (req.rd & req.wr) | (req_any & req.addr[0]);
`else
  assign err_raw = req.rd & req.wr;
`endif

  // Reset masks every request-side output and blocks acceptance.
  assign err   = ~rst & err_raw;
  assign stall = ~rst & req_any & ~err_raw & busy[bsel];
  assign acc   = ~rst & req_any & ~err_raw & ~busy[bsel];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    mem_bank #(
      .BANK_CYCLES(BANK_CYCLES),
      .ROW_BITS   (ROW_BITS)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .acc   (acc && (bsel == bank_sel_t'(i))),
      .wr    (req.wr),
      .row   (row),
      .wdata (req.data),
      .busy  (busy[i]),
      .rd_vld(rd_vld[i]),
      .rd_dat(rd_dat[i])
    );
  end

  // One-hot OR mux: at most one bank returns data per cycle, idle banks drive zero.
  always_comb begin
    data_out   = '0;
    data_valid = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      data_out   = data_out | rd_dat[i];
      data_valid = data_valid | rd_vld[i];
    end
  end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed self-checking bench for banked_mem_responder.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Each scenario task checks its own expectations inline.
module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  banked_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .wr        (wr),
    .rd        (rd),
    .data_out  (data_out),
    .data_valid(data_valid),
    .stall     (stall),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd      = r;
    wr      = w;
    addr    = a;
    data_in = d;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
    chk_cnt++; if (err !== 1'b0) $display("FAIL rst_err: err=%b exp=0", err); else pass_cnt++;
    step();
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: stall=%b exp=0", stall); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL rst_busy: busy=%b exp=0000", busy); else pass_cnt++;
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL rst_dv: data_valid=%b exp=0", data_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0000) $display("FAIL rst_dout: data_out=%h exp=0000", data_out); else pass_cnt++;
    step();
    rst = 1'b0;
    idle(1);
    // A read presented during reset must not have been accepted.
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL rst_noacc_dv: data_valid=%b exp=0", data_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL rst_noacc_busy: busy=%b exp=0000", busy); else pass_cnt++;
  endtask

  task automatic preload();
    logic [15:0] pa [7];
    logic [15:0] pd [7];
    pa = '{16'h0000, 16'h0008, 16'h0002, 16'h0100, 16'h0102, 16'h0104, 16'h0106};
    pd = '{16'hC0DE, 16'hBEEF, 16'h1234, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, pa[i], pd[i]);
      step();
      idle(3);
    end
  endtask

  task automatic test_write_read();
    idle(4);
    drive(1'b0, 1'b1, 16'h0040, 16'hA5A5);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL wr_stall: stall=%b exp=0", stall); else pass_cnt++;
    step();
    idle(0);
    chk_cnt++; if (busy !== 4'b0001) $display("FAIL wr_busy: busy=%b exp=0001", busy); else pass_cnt++;
    step();
    idle(2);
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL wr_rd_stall: stall=%b exp=0", stall); else pass_cnt++;
    step();
    idle(0);
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL wr_rd_early: data_valid=%b exp=0", data_valid); else pass_cnt++;
    step();
    chk_cnt++; if (data_valid !== 1'b1) $display("FAIL wr_rd_dv: data_valid=%b exp=1", data_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'hA5A5) $display("FAIL wr_rd_data: data_out=%h exp=a5a5", data_out); else pass_cnt++;
    step();
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL wr_rd_late: data_valid=%b exp=0", data_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0000) $display("FAIL wr_rd_zero: data_out=%h exp=0000", data_out); else pass_cnt++;
  endtask

  task automatic test_line_fill();
    logic [15:0] exp [4];
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    idle(4);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 16'h0100 + 16'(2 * k), 16'h0000);
      else       drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      if (k < 4) begin
        chk_cnt++; if (stall !== 1'b0) $display("FAIL fill_stall k=%0d: stall=%b exp=0", k, stall); else pass_cnt++;
      end
      if (k == 1) begin
        chk_cnt++; if (busy !== 4'b0001) $display("FAIL fill_busy: busy=%b exp=0001", busy); else pass_cnt++;
      end
      if (k >= 2 && k < 6) begin
        chk_cnt++; if (data_valid !== 1'b1) $display("FAIL fill_dv k=%0d: data_valid=%b exp=1", k, data_valid); else pass_cnt++;
        chk_cnt++; if (data_out !== exp[k-2]) $display("FAIL fill_data k=%0d: data_out=%h exp=%h", k, data_out, exp[k-2]); else pass_cnt++;
      end else begin
        chk_cnt++; if (data_valid !== 1'b0) $display("FAIL fill_nodv k=%0d: data_valid=%b exp=0", k, data_valid); else pass_cnt++;
      end
      step();
    end
  endtask

  task automatic test_bank_conflict();
    idle(4);
    drive(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL conf_first: stall=%b exp=0", stall); else pass_cnt++;
    step();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 16'h0000, 16'h0000);
      chk_cnt++; if (stall !== 1'b1) $display("FAIL conf_stall k=%0d: stall=%b exp=1", k, stall); else pass_cnt++;
      if (k == 2) begin
        chk_cnt++; if (data_out !== 16'hBEEF || data_valid !== 1'b1) $display("FAIL conf_data1: dv=%b data_out=%h exp dv=1 beef", data_valid, data_out); else pass_cnt++;
      end
      step();
    end
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL conf_accept: stall=%b exp=0", stall); else pass_cnt++;
    step();
    idle(0);
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL conf_early: data_valid=%b exp=0", data_valid); else pass_cnt++;
    step();
    chk_cnt++; if (data_out !== 16'hC0DE || data_valid !== 1'b1) $display("FAIL conf_data2: dv=%b data_out=%h exp dv=1 c0de", data_valid, data_out); else pass_cnt++;
  endtask

  task automatic test_err();
    idle(4);
    drive(1'b1, 1'b0, 16'h0002, 16'h0000);
    step();
    // Illegal request to a bank that is busy: err wins, no stall, no occupancy.
    drive(1'b1, 1'b1, 16'h0002, 16'hDEAD);
    chk_cnt++; if (err !== 1'b1) $display("FAIL err_flag: err=%b exp=1", err); else pass_cnt++;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL err_stall: stall=%b exp=0", stall); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0010) $display("FAIL err_busy: busy=%b exp=0010", busy); else pass_cnt++;
    step();
    idle(0);
    chk_cnt++; if (err !== 1'b0) $display("FAIL err_clear: err=%b exp=0", err); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h1234 || data_valid !== 1'b1) $display("FAIL err_prev_rd: dv=%b data_out=%h exp dv=1 1234", data_valid, data_out); else pass_cnt++;
    step();
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL err_nodv: data_valid=%b exp=0", data_valid); else pass_cnt++;
    step();
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL err_busy_free: busy=%b exp=0000", busy); else pass_cnt++;
    drive(1'b1, 1'b0, 16'h0002, 16'h0000);
    step();
    idle(1);
    chk_cnt++; if (data_out !== 16'h1234 || data_valid !== 1'b1) $display("FAIL err_mem_kept: dv=%b data_out=%h exp dv=1 1234", data_valid, data_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    idle(4);
    drive(1'b0, 1'b1, 16'h0106, 16'h7777);
    step();
    drive(1'b1, 1'b0, 16'h0100, 16'h0000);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL b2b_stall: stall=%b exp=0", stall); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b1000) $display("FAIL b2b_busy: busy=%b exp=1000", busy); else pass_cnt++;
    step();
    idle(1);
    chk_cnt++; if (data_out !== 16'h1111 || data_valid !== 1'b1) $display("FAIL b2b_rd: dv=%b data_out=%h exp dv=1 1111", data_valid, data_out); else pass_cnt++;
    step();
    drive(1'b1, 1'b0, 16'h0106, 16'h0000);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL b2b_rd3_stall: stall=%b exp=0", stall); else pass_cnt++;
    step();
    idle(1);
    chk_cnt++; if (data_out !== 16'h7777 || data_valid !== 1'b1) $display("FAIL b2b_wrdata: dv=%b data_out=%h exp dv=1 7777", data_valid, data_out); else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    idle(4);
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0102, 16'h0000);
    chk_cnt++; if (err !== 1'b0) $display("FAIL rstf_err: err=%b exp=0", err); else pass_cnt++;
    step();
    rst = 1'b0;
    idle(0);
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL rstf_dv: data_valid=%b exp=0", data_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0000) $display("FAIL rstf_dout: data_out=%h exp=0000", data_out); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL rstf_busy: busy=%b exp=0000", busy); else pass_cnt++;
    step();
    chk_cnt++; if (data_valid !== 1'b0) $display("FAIL rstf_dv2: data_valid=%b exp=0", data_valid); else pass_cnt++;
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    step();
    idle(1);
    chk_cnt++; if (data_out !== 16'hA5A5 || data_valid !== 1'b1) $display("FAIL rstf_mem: dv=%b data_out=%h exp dv=1 a5a5", data_valid, data_out); else pass_cnt++;
  endtask

  task automatic test_align();
    logic        exp_err;
    logic [15:0] exp_word;
`ifdef MEM_ALIGN_CHECK_EN
    exp_err  = 1'b1;
    exp_word = 16'h1234;
`else
    exp_err  = 1'b0;
    exp_word = 16'h5A5A;
`endif
    idle(4);
    drive(1'b0, 1'b1, 16'h0003, 16'h5A5A);
    chk_cnt++; if (err !== exp_err) $display("FAIL align_err: err=%b exp=%b", err, exp_err); else pass_cnt++;
    step();
    idle(4);
    drive(1'b1, 1'b0, 16'h0002, 16'h0000);
    step();
    idle(1);
    chk_cnt++; if (data_out !== exp_word || data_valid !== 1'b1) $display("FAIL align_word: dv=%b data_out=%h exp dv=1 %h", data_valid, data_out, exp_word); else pass_cnt++;
  endtask

  initial begin
    rst     = 1'b1;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = 16'h0000;
    data_in = 16'h0000;
    #1;
    test_reset();
    preload();
    test_write_read();
    test_line_fill();
    test_bank_conflict();
    test_err();
    test_back_to_back();
    test_reset_inflight();
    test_align();
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
